mask_shares_unit: RTL and testbench

Masking front-end: takes an unshared `count`-bit word and `(d-1)*count` fresh random bits, and emits a `d`-share Boolean sharing of the word in sharing-major ("shares") layout, so the result can be fed to masked cores and to `shares2shbus`. It is the inverse of the bench-side recombination path. It buffers up to two shared words behind a valid/ready handshake so the producer, the randomness source and the consumer are decoupled.

---
 rtl/mask_shares_unit.sv | 80 ++++++++
 tb/tb_mask_shares_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mask_shares_unit.sv
// Boolean masking front-end: splits a word into d shares using fresh randomness
// and buffers up to two shared words behind valid/ready handshakes.
module mask_shares_unit #(
  parameter int d     = 2,
  parameter int count = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [count-1:0]       in_data,
  input  logic                   rnd_valid,
  output logic                   rnd_ready,
  input  logic [(d-1)*count-1:0] rnd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [d*count-1:0]     out_shares
);

  localparam int W = d * count;

  if (d < 2) begin : g_bad_d
    $error("mask_shares_unit: d must be >= 2");
  end

  logic [W-1:0]        shares_d;
  logic [count-1:0]    share0_d;
  logic [1:0][W-1:0]   mem_q;
  logic [1:0]          occ_q, occ_d;
  logic                wptr_q, rptr_q;
  logic                full, push, pop;

  // Shares 1..d-1 are the random chunks verbatim; share 0 absorbs the data.
  for (genvar i = 1; i < d; i++) begin : g_share
    assign shares_d[i*count +: count] = rnd[(i-1)*count +: count];
  end

  always_comb begin
    share0_d = in_data;
    for (int j = 0; j < d - 1; j++) share0_d = share0_d ^ rnd[j*count +: count];
  end

  assign shares_d[count-1:0] = share0_d;

  // full is registered state only, so a pop at occ==2 cannot admit a push.
  assign full       = (occ_q == 2'd2);
  assign out_valid  = (occ_q != 2'd0);
  assign out_shares = mem_q[rptr_q];
  assign in_ready   = rnd_valid & ~full;
  assign rnd_ready  = in_valid & ~full;
  assign push       = in_valid & rnd_valid & ~full;
  assign pop        = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= 2'd0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      if (push) wptr_q <= ~wptr_q;
      if (pop)  rptr_q <= ~rptr_q;
    end
  end

  // Payload is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wptr_q] <= shares_d;
  end

endmodule

// File: tb/tb_mask_shares_unit.sv
// Bench for mask_shares_unit: a d=2 and a d=3 instance checked every cycle
// against a queue-based model, plus hand-computed literal vectors.
module tb_mask_shares_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv2 = 0, rv2 = 0, or2 = 0;
  logic [7:0]  din2 = 0, rnd2 = 0;
  logic        ir2, rr2, ov2;
  logic [15:0] sh2;

  logic        iv3 = 0, rv3 = 0, or3 = 0;
  logic [7:0]  din3 = 0;
  logic [15:0] rnd3 = 0;
  logic        ir3, rr3, ov3;
  logic [23:0] sh3;

  mask_shares_unit #(.d(2), .count(8)) u_d2 (
    .clk(clk), .rst(rst),
    .in_valid(iv2), .in_ready(ir2), .in_data(din2),
    .rnd_valid(rv2), .rnd_ready(rr2), .rnd(rnd2),
    .out_valid(ov2), .out_ready(or2), .out_shares(sh2)
  );

  mask_shares_unit #(.d(3), .count(8)) u_d3 (
    .clk(clk), .rst(rst),
    .in_valid(iv3), .in_ready(ir3), .in_data(din3),
    .rnd_valid(rv3), .rnd_ready(rr3), .rnd(rnd3),
    .out_valid(ov3), .out_ready(or3), .out_shares(sh3)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Share i = chunk i-1, share 0 = data XOR every chunk.
  function automatic logic [23:0] share_fn(input int dd, input logic [7:0] x, input logic [15:0] r);
    logic [23:0] s;
    logic [7:0]  acc;
    s   = '0;
    acc = x;
    for (int j = 1; j < dd; j++) begin
      s[j*8 +: 8] = r[(j-1)*8 +: 8];
      acc = acc ^ r[(j-1)*8 +: 8];
    end
    s[7:0] = acc;
    return s;
  endfunction

  logic [23:0] mq2[$], mq3[$];
  logic [7:0]  dq2[$], dq3[$];
  int push3 = 0, pop3 = 0, dacc3 = 0, racc3 = 0;
  bit p2, q2, p3, q3;

  always @(posedge clk) begin
    if (rst) begin
      mq2.delete(); dq2.delete(); mq3.delete(); dq3.delete();
    end else begin
      p2 = iv2 && rv2 && (mq2.size() < 2);
      q2 = (mq2.size() != 0) && or2;
      if (q2) begin void'(mq2.pop_front()); void'(dq2.pop_front()); end
      if (p2) begin mq2.push_back(share_fn(2, din2, {8'h00, rnd2})); dq2.push_back(din2); end
      p3 = iv3 && rv3 && (mq3.size() < 2);
      q3 = (mq3.size() != 0) && or3;
      if (q3) begin void'(mq3.pop_front()); void'(dq3.pop_front()); pop3++; end
      if (p3) begin mq3.push_back(share_fn(3, din3, rnd3)); dq3.push_back(din3); push3++; end
      if (iv3 && ir3) dacc3++;
      if (rv3 && rr3) racc3++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ov2", 32'(ov2), 32'(mq2.size() != 0));
      chk("ir2", 32'(ir2), 32'(rv2 && mq2.size() < 2));
      chk("rr2", 32'(rr2), 32'(iv2 && mq2.size() < 2));
      if (mq2.size() != 0) begin
        chk("sh2", 32'(sh2), 32'(mq2[0][15:0]));
        chk("xor2", 32'(sh2[15:8] ^ sh2[7:0]), 32'(dq2[0]));
      end
      chk("ov3", 32'(ov3), 32'(mq3.size() != 0));
      chk("ir3", 32'(ir3), 32'(rv3 && mq3.size() < 2));
      chk("rr3", 32'(rr3), 32'(iv3 && mq3.size() < 2));
      if (mq3.size() != 0) begin
        chk("sh3", 32'(sh3), 32'(mq3[0]));
        chk("xor3", 32'(sh3[23:16] ^ sh3[15:8] ^ sh3[7:0]), 32'(dq3[0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int base_push, base_pop, base_d, base_r, cyc;

  initial begin
    // reset then idle
    rst = 1;
    step(); step();
    rst = 0;
    chk_en = 1;
    @(negedge clk);
    chk("rst_ov2", 32'(ov2), 0);
    chk("rst_ir2", 32'(ir2), 0);
    chk("rst_rr2", 32'(rr2), 0);
    chk("rst_ov3", 32'(ov3), 0);

    // single word d=2
    iv2 = 1; rv2 = 1; din2 = 8'hA5; rnd2 = 8'h3C; or2 = 1;
    step();
    iv2 = 0; rv2 = 0;
    @(negedge clk);
    chk("single_sh", 32'(sh2), 32'h3C99);
    chk("single_ov", 32'(ov2), 1);
    step();
    @(negedge clk);
    chk("single_ov_off", 32'(ov2), 0);

    // randomness starvation
    iv2 = 1; rv2 = 0; din2 = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("starve_ir", 32'(ir2), 0);
      chk("starve_ov", 32'(ov2), 0);
      step();
    end
    rv2 = 1; rnd2 = 8'hFF;
    step();
    iv2 = 0; rv2 = 0;
    @(negedge clk);
    chk("starve_sh", 32'(sh2), 32'hFFF0);
    step();

    // backpressure
    or2 = 0; iv2 = 1; rv2 = 1; rnd2 = 8'h00; din2 = 8'h01;
    step();
    din2 = 8'h02;
    step();
    din2 = 8'h03;
    @(negedge clk);
    chk("bp_full_ir", 32'(ir2), 0);
    chk("bp_head1", 32'(sh2), 32'h0001);
    step();
    @(negedge clk);
    chk("bp_hold_ir", 32'(ir2), 0);
    chk("bp_hold_sh", 32'(sh2), 32'h0001);
    or2 = 1;
    step();
    @(negedge clk);
    chk("bp_head2", 32'(sh2), 32'h0002);
    chk("bp_ir_open", 32'(ir2), 1);
    step();
    iv2 = 0; rv2 = 0;
    @(negedge clk);
    chk("bp_head3", 32'(sh2), 32'h0003);
    step();
    @(negedge clk);
    chk("bp_empty", 32'(ov2), 0);

    // reset mid-flight at occ=2
    or2 = 0; iv2 = 1; rv2 = 1; din2 = 8'h11; rnd2 = 8'h22;
    step();
    din2 = 8'h33;
    step();
    iv2 = 0; rv2 = 0;
    @(negedge clk);
    chk("mid_full_ov", 32'(ov2), 1);
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("mid_flush_ov", 32'(ov2), 0);
    or2 = 1; iv2 = 1; rv2 = 1; din2 = 8'h5A; rnd2 = 8'h11;
    step();
    iv2 = 0; rv2 = 0;
    @(negedge clk);
    chk("mid_after_sh", 32'(sh2), 32'h114B);
    step();

    // single word d=3
    or3 = 1; iv3 = 1; rv3 = 1; din3 = 8'h5A; rnd3 = 16'h1234;
    step();
    iv3 = 0; rv3 = 0;
    @(negedge clk);
    chk("d3_sh", 32'(sh3), 32'h12347C);
    step();

    // streaming d=3 with random handshakes
    base_push = push3; base_pop = pop3; base_d = dacc3; base_r = racc3;
    cyc = 0;
    while (push3 - base_push < 256 && cyc < 6000) begin
      iv3  = ($urandom_range(3) != 0);
      rv3  = ($urandom_range(3) != 0);
      din3 = 8'($urandom);
      rnd3 = 16'($urandom);
      or3  = 1'($urandom_range(1));
      step();
      cyc++;
    end
    iv3 = 0; rv3 = 0; or3 = 1;
    cyc = 0;
    while (mq3.size() != 0 && cyc < 20) begin
      step();
      cyc++;
    end
    @(negedge clk);
    chk("stream_pushes", 32'(push3 - base_push), 256);
    chk("stream_pops", 32'(pop3 - base_pop), 256);
    chk("stream_data_acc", 32'(dacc3 - base_d), 256);
    chk("stream_rnd_eq_data", 32'(racc3 - base_r), 32'(dacc3 - base_d));
    chk("stream_drained", 32'(ov3), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
